uart_cmd_ctrl: RTL
==================

Name: uart_cmd_ctrl

Overview:
Command sequencer between the UART receive path and the SDRAM controller. Parses byte packets arriving from the UART receiver into single-word SDRAM write/read requests. Returns the read data, or a write acknowledge byte, through the UART transmitter. Sits at top level between the receiver's data/data_valid outputs, the SDRAM controller request port and the transmitter input.

Parameters:
CLK_FREQ, 50_000_000, system clock frequency in Hz (informational; used to derive TIMEOUT_CYC)
TIMEOUT_CYC, 50_000, maximum idle cycles between bytes of one packet (1 ms at 50 MHz)
ADDR_W, 24, SDRAM word address width; must be ≤24
ACK_BYTE, 8'h4B, byte returned after a completed write ('K')

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  asynchronous active-high reset
rx_data  in  8  received byte
rx_valid  in  1  single-cycle strobe; rx_data valid this cycle
mem_req  out  1  SDRAM request, held until accepted
mem_we  out  1  1 = write, 0 = read; stable while mem_req
mem_addr  out  ADDR_W  word address; stable while mem_req
mem_wdata  out  16  write data; stable while mem_req
mem_ack  in  1  request accepted in the cycle where mem_req && mem_ack
mem_rdata  in  16  read data
mem_rvalid  in  1  single-cycle strobe; mem_rdata valid
tx_data  out  8  byte to transmit
tx_valid  out  1  byte offered; held with stable tx_data until tx_ready
tx_ready  in  1  transmitter can accept; transfer when tx_valid && tx_ready
busy  out  1  high in any state other than IDLE
err  out  1  single-cycle pulse on protocol error

Behaviour:
- Asynchronous reset: state IDLE. All outputs 0, counters 0. A partial packet or outstanding request is discarded. Reset mid-transaction needs no SDRAM-side cleanup; any late mem_rvalid is ignored in IDLE.
- Packet formats, bytes big-endian:
  - Write: 0x57 ('W'), A2, A1, A0, D1, D0.
  - Read: 0x52 ('R'), A2, A1, A0.
  - Address = {A2,A1,A0}[ADDR_W-1:0].
- States and transitions:
  - IDLE: rx_valid with 0x57 → ADDR with we=1; with 0x52 → ADDR with we=0. Any other byte is dropped, err pulses, stay in IDLE.
  - ADDR: shift in 3 bytes (2-bit counter). After the 3rd byte: we=1 → WDATA; we=0 → MEM_REQ.
  - WDATA: shift in 2 bytes; after the 2nd → MEM_REQ.
  - MEM_REQ: mem_req=1. In the cycle mem_ack=1, mem_req drops the next cycle. Then we=1 → SEND_ACK; we=0 → RD_WAIT.
  - RD_WAIT: on mem_rvalid, capture mem_rdata → SEND_HI. mem_rvalid in the same cycle as mem_ack is not possible (controller latency ≥1).
  - SEND_HI / SEND_LO / SEND_ACK: tx_valid=1 with tx_data = rdata[15:8] / rdata[7:0] / ACK_BYTE. On handshake go to SEND_LO / IDLE / IDLE respectively.
- Latency: mem_req rises the cycle after the rx_valid of the final packet byte. tx_valid rises the cycle after mem_rvalid (read) or after mem_ack (write).
- Timeout: in ADDR and WDATA, a 16-bit counter clears on every rx_valid and increments otherwise. When it reaches TIMEOUT_CYC-1: go to IDLE, err pulses, partial packet discarded.
- rx_valid while in MEM_REQ, RD_WAIT or any SEND state: byte dropped, err pulses, state unaffected.
- rx_valid in the same cycle as a timeout: the byte is accepted and the counter is cleared (no error).
- mem_req, mem_addr, mem_wdata and mem_we must not change while mem_req=1 and mem_ack=0.
- One outstanding memory request maximum; no pipelining of packets.

Decomposition:
- Shared package uart_sdram_pkg: command byte constants CMD_WR=8'h57, CMD_RD=8'h52, ACK_BYTE default, state enum encoding, ADDR_W default.
- One natural sub-module, cmd_timeout_cnt: clear/enable counter asserting expired at TIMEOUT_CYC-1.
- FSM and packet shift registers stay in uart_cmd_ctrl.

Test Plan:
- Write: bytes 57 00 01 23 BE EF, mem_ack 2 cycles after req → one request: we=1, addr=0x000123, wdata=0xBEEF. Then tx byte 0x4B, busy returns 0.
- Read: bytes 52 00 01 23, ack after 1 cycle, mem_rvalid with 0xBEEF 5 cycles later → tx bytes 0xBE then 0xEF. tx_ready held low 10 cycles first: tx_valid stays high, tx_data stable at 0xBE.
- Bad command: byte 0x41 in IDLE → err pulse, no mem_req, busy stays 0. Following valid write packet completes normally.
- Timeout: bytes 57 00 01, then silence TIMEOUT_CYC cycles → err pulse at count TIMEOUT_CYC-1, state IDLE, no mem_req. A byte arriving exactly on the expiry cycle instead continues the packet.
- Busy drop: during RD_WAIT send byte 0x52 → err pulse; read completes with the correct 2 tx bytes and no second request.
- Reset mid-packet: assert rst during WDATA and during MEM_REQ → all outputs 0 immediately. Next full packet executes correctly.

Source files
------------

// File: rtl/uart_sdram_pkg.sv
// Shared constants and state encoding for the UART-to-SDRAM command path.
package uart_sdram_pkg;

  localparam logic [7:0] CMD_WR       = 8'h57;
  localparam logic [7:0] CMD_RD       = 8'h52;
  localparam logic [7:0] ACK_BYTE_DEF = 8'h4B;
  localparam int         ADDR_W_DEF   = 24;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ADDR     = 3'd1,
    ST_WDATA    = 3'd2,
    ST_MEM_REQ  = 3'd3,
    ST_RD_WAIT  = 3'd4,
    ST_SEND_HI  = 3'd5,
    ST_SEND_LO  = 3'd6,
    ST_SEND_ACK = 3'd7
  } state_e;

endpackage

// File: rtl/uart_cmd_ctrl_timeout_cnt.sv
// Inter-byte idle counter: cleared by clr, counts while en, flags expiry at TIMEOUT_CYC-1.
module cmd_timeout_cnt #(
  parameter int TIMEOUT_CYC = 50_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam logic [15:0] LIMIT = 16'(TIMEOUT_CYC - 1);

  logic [15:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en && !expired) begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

  assign expired = en && (cnt_q == LIMIT);

endmodule

// File: rtl/uart_cmd_ctrl.sv
// Parses UART byte packets into single-word SDRAM reads/writes and returns
// read data or a write acknowledge byte through the UART transmitter.
module uart_cmd_ctrl
  import uart_sdram_pkg::*;
#(
  parameter int         CLK_FREQ    = 50_000_000,
  parameter int         TIMEOUT_CYC = CLK_FREQ / 1000,
  parameter int         ADDR_W      = ADDR_W_DEF,
  parameter logic [7:0] ACK_BYTE    = ACK_BYTE_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  input  logic              mem_ack,
  input  logic [15:0]       mem_rdata,
  input  logic              mem_rvalid,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              busy,
  output logic              err
);

  state_e      state_q, state_d;
  logic        we_q;
  logic [1:0]  byte_cnt_q;
  logic [23:0] addr_sr_q;
  logic [15:0] wdata_sr_q;
  logic [15:0] rdata_q;
  logic        err_q;

  logic        err_d;
  logic        addr_shift;
  logic        wdata_shift;
  logic        rdata_cap;
  logic        we_load;
  logic        rx_phase;
  logic        expired;

  assign rx_phase = (state_q == ST_ADDR) || (state_q == ST_WDATA);

  cmd_timeout_cnt #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .clr    (rx_valid || !rx_phase),
    .en     (rx_phase),
    .expired(expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // An arriving byte always wins over a simultaneous timeout.
  always_comb begin
    state_d     = state_q;
    err_d       = 1'b0;
    addr_shift  = 1'b0;
    wdata_shift = 1'b0;
    rdata_cap   = 1'b0;
    we_load     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (rx_valid) begin
          if (rx_data == CMD_WR || rx_data == CMD_RD) begin
            state_d = ST_ADDR;
            we_load = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_ADDR: begin
        if (rx_valid) begin
          addr_shift = 1'b1;
          if (byte_cnt_q == 2'd2) begin
            state_d = we_q ? ST_WDATA : ST_MEM_REQ;
          end
        end else if (expired) begin
          state_d = ST_IDLE;
          err_d   = 1'b1;
        end
      end
      ST_WDATA: begin
        if (rx_valid) begin
          wdata_shift = 1'b1;
          if (byte_cnt_q == 2'd1) begin
            state_d = ST_MEM_REQ;
          end
        end else if (expired) begin
          state_d = ST_IDLE;
          err_d   = 1'b1;
        end
      end
      ST_MEM_REQ: begin
        err_d = rx_valid;
        if (mem_ack) begin
          state_d = we_q ? ST_SEND_ACK : ST_RD_WAIT;
        end
      end
      ST_RD_WAIT: begin
        err_d = rx_valid;
        if (mem_rvalid) begin
          rdata_cap = 1'b1;
          state_d   = ST_SEND_HI;
        end
      end
      ST_SEND_HI: begin
        err_d = rx_valid;
        if (tx_ready) state_d = ST_SEND_LO;
      end
      ST_SEND_LO: begin
        err_d = rx_valid;
        if (tx_ready) state_d = ST_IDLE;
      end
      ST_SEND_ACK: begin
        err_d = rx_valid;
        if (tx_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Packet registers only move in the receive states, so the request stays stable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_q       <= 1'b0;
      byte_cnt_q <= '0;
      addr_sr_q  <= '0;
      wdata_sr_q <= '0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      err_q <= err_d;
      if (we_load) we_q <= (rx_data == CMD_WR);
      if (state_d != state_q) begin
        byte_cnt_q <= '0;
      end else if (addr_shift || wdata_shift) begin
        byte_cnt_q <= byte_cnt_q + 2'd1;
      end
      if (addr_shift)  addr_sr_q  <= {addr_sr_q[15:0], rx_data};
      if (wdata_shift) wdata_sr_q <= {wdata_sr_q[7:0], rx_data};
      if (rdata_cap)   rdata_q    <= mem_rdata;
    end
  end

  always_comb begin
    tx_data = 8'h00;
    case (state_q)
      ST_SEND_HI:  tx_data = rdata_q[15:8];
      ST_SEND_LO:  tx_data = rdata_q[7:0];
      ST_SEND_ACK: tx_data = ACK_BYTE;
      default:     tx_data = 8'h00;
    endcase
  end

  assign mem_req   = (state_q == ST_MEM_REQ);
  assign mem_we    = we_q;
  assign mem_addr  = addr_sr_q[ADDR_W-1:0];
  assign mem_wdata = wdata_sr_q;
  assign tx_valid  = (state_q == ST_SEND_HI) || (state_q == ST_SEND_LO) ||
                     (state_q == ST_SEND_ACK);
  assign busy      = (state_q != ST_IDLE);
  assign err       = err_q;

endmodule
